// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_WAIT = 2'd1,
      FS_HOLD = 2'd2
   } fs_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a returned instruction and its PC while
// decode is stalled. Clear has priority over load.
module fetch_hold_buf
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] wr_instr,
   input  logic [XLEN-1:0] wr_pc,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic            valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= XLEN'(NOP_INSTR);
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= wr_instr;
         pc    <= wr_pc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, hold
// buffer and the if2id pipeline register.
//
// state   | meaning
// FS_IDLE | request presented at PC, waiting for grant
// FS_WAIT | one request outstanding, waiting for rvalid (stale => drop it)
// FS_HOLD | returned word parked in hold buffer until stalls clear
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            Stall_if,
   input  logic            Stall_id,
   input  logic            Redirect,
   input  logic [XLEN-1:0] Redirect_pc,
   output logic            Imem_req,
   output logic [XLEN-1:0] Imem_addr,
   input  logic            Imem_gnt,
   input  logic            Imem_rvalid,
   input  logic [XLEN-1:0] Imem_rdata,
   output logic [XLEN-1:0] Instr_if2id,
   output logic [XLEN-1:0] Pc_if2id,
   output logic            Valid_if2id
);

   fs_state_t       state, state_nxt;
   logic            stale, stale_nxt;
   logic [XLEN-1:0] pc;

   logic            no_stall;
   logic            rsp_take;
   logic            deliver_rsp;
   logic            hold_load;
   logic            deliver_hold;
   logic            deliver;
   logic [XLEN-1:0] deliver_instr;
   logic [XLEN-1:0] deliver_pc;
   logic [XLEN-1:0] hold_instr;
   logic [XLEN-1:0] hold_pc;
   logic            hold_valid;

   assign no_stall      = !Stall_if && !Stall_id;
   // A response that arrives alongside a redirect belongs to the old path.
   assign rsp_take      = (state == FS_WAIT) && Imem_rvalid && !stale && !Redirect;
   assign deliver_rsp   = rsp_take && no_stall;
   assign hold_load     = rsp_take && !no_stall;
   assign deliver_hold  = (state == FS_HOLD) && hold_valid && !Redirect && no_stall;
   assign deliver       = deliver_rsp || deliver_hold;
   assign deliver_instr = deliver_hold ? hold_instr : Imem_rdata;
   assign deliver_pc    = deliver_hold ? hold_pc : pc;

   fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
      .clk      (Clk),
      .rst      (Rst),
      .load     (hold_load),
      .clear    (Redirect || deliver_hold),
      .wr_instr (Imem_rdata),
      .wr_pc    (pc),
      .instr    (hold_instr),
      .pc       (hold_pc),
      .valid    (hold_valid)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= FS_IDLE;
         stale <= 1'b0;
      end else begin
         state <= state_nxt;
         stale <= stale_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stale_nxt = stale;
      case (state)
         FS_IDLE: begin
            if (Imem_gnt) begin
               state_nxt = FS_WAIT;
               stale_nxt = Redirect;
            end
         end
         FS_WAIT: begin
            if (Imem_rvalid) begin
               state_nxt = hold_load ? FS_HOLD : FS_IDLE;
               stale_nxt = 1'b0;
            end else if (Redirect) begin
               stale_nxt = 1'b1;
            end
         end
         FS_HOLD: begin
            if (Redirect || deliver_hold || !hold_valid) state_nxt = FS_IDLE;
         end
         default: begin
            state_nxt = FS_IDLE;
            stale_nxt = 1'b0;
         end
      endcase
   end

   always_comb begin
      Imem_req  = (state == FS_IDLE) && !Rst;
      Imem_addr = pc;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pc <= RESET_PC;
      end else if (Redirect) begin
         pc <= Redirect_pc & ~XLEN'(3);
      end else if (deliver) begin
         pc <= pc + XLEN'(4);
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Instr_if2id <= XLEN'(NOP_INSTR);
         Pc_if2id    <= '0;
         Valid_if2id <= 1'b0;
      end else if (Redirect) begin
         Instr_if2id <= XLEN'(NOP_INSTR);
         Valid_if2id <= 1'b0;
      end else if (!Stall_id) begin
         if (!Stall_if && deliver) begin
            Instr_if2id <= deliver_instr;
            Pc_if2id    <= deliver_pc;
            Valid_if2id <= 1'b1;
         end else begin
            Instr_if2id <= XLEN'(NOP_INSTR);
            Valid_if2id <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait grant memory responder and
// cycle-accurate expected values for stalls, redirects, wrap and reset.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Stall_if, Stall_id, Redirect;
   logic [31:0] Redirect_pc;
   logic        Imem_req;
   logic [31:0] Imem_addr;
   logic        Imem_gnt, Imem_rvalid;
   logic [31:0] Imem_rdata;
   logic [31:0] Instr_if2id, Pc_if2id;
   logic        Valid_if2id;

   logic        hold_rsp;
   logic        pend;
   logic [31:0] paddr;
   int          total = 0;
   int          bad   = 0;

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Stall_if    (Stall_if),
      .Stall_id    (Stall_id),
      .Redirect    (Redirect),
      .Redirect_pc (Redirect_pc),
      .Imem_req    (Imem_req),
      .Imem_addr   (Imem_addr),
      .Imem_gnt    (Imem_gnt),
      .Imem_rvalid (Imem_rvalid),
      .Imem_rdata  (Imem_rdata),
      .Instr_if2id (Instr_if2id),
      .Pc_if2id    (Pc_if2id),
      .Valid_if2id (Valid_if2id)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] instr_at(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : (32'hA000_0000 | a);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clk);
   endtask

   // Memory: grant always, rvalid one cycle later unless hold_rsp stretches it.
   initial begin
      Imem_rvalid = 1'b0;
      Imem_rdata  = '0;
      pend        = 1'b0;
      paddr       = '0;
      forever begin
         @(negedge Clk);
         if (Rst) pend = 1'b0;
         else if (Imem_req && Imem_gnt) begin
            pend  = 1'b1;
            paddr = Imem_addr;
         end
         @(posedge Clk);
         #1;
         if (Rst) pend = 1'b0;
         if (pend && !hold_rsp) begin
            Imem_rvalid = 1'b1;
            Imem_rdata  = instr_at(paddr);
            pend        = 1'b0;
         end else begin
            Imem_rvalid = 1'b0;
            Imem_rdata  = '0;
         end
      end
   end

   initial begin
      Rst = 1'b1; Stall_if = 1'b0; Stall_id = 1'b0; Redirect = 1'b0;
      Redirect_pc = '0; Imem_gnt = 1'b1; hold_rsp = 1'b0;
      tick(); tick();
      check("rst_instr", Instr_if2id, NOP);
      check("rst_pc", Pc_if2id, 32'h0);
      check("rst_valid", 32'(Valid_if2id), 32'd0);
      check("rst_req", 32'(Imem_req), 32'd0);

      @(posedge Clk); #1 Rst = 1'b0;
      tick();
      check("first_req", 32'(Imem_req), 32'd1);
      check("first_addr", Imem_addr, 32'h0);
      tick(); tick();
      check("d0_pc", Pc_if2id, 32'h0);
      check("d0_instr", Instr_if2id, 32'h0050_0093);
      check("d0_valid", 32'(Valid_if2id), 32'd1);
      check("d0_next_addr", Imem_addr, 32'h4);
      tick(); tick();
      check("d4_pc", Pc_if2id, 32'h4);
      tick(); tick();
      check("d8_pc", Pc_if2id, 32'h8);
      check("d8_next_addr", Imem_addr, 32'hC);

      Stall_id = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sid_pc", Pc_if2id, 32'h8);
         check("sid_instr", Instr_if2id, instr_at(32'h8));
         check("sid_valid", 32'(Valid_if2id), 32'd1);
         check("sid_addr", Imem_addr, 32'hC);
      end
      check("sid_req_hold", 32'(Imem_req), 32'd0);
      Stall_id = 1'b0;
      tick();
      check("sid_rel_pc", Pc_if2id, 32'hC);
      check("sid_rel_instr", Instr_if2id, instr_at(32'hC));
      check("sid_rel_valid", 32'(Valid_if2id), 32'd1);
      check("sid_rel_addr", Imem_addr, 32'h10);

      Stall_if = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("sif_instr", Instr_if2id, NOP);
         check("sif_valid", 32'(Valid_if2id), 32'd0);
         check("sif_addr", Imem_addr, 32'h10);
      end
      Stall_if = 1'b0;
      tick();
      check("sif_rel_pc", Pc_if2id, 32'h10);
      check("sif_rel_valid", 32'(Valid_if2id), 32'd1);
      check("sif_rel_addr", Imem_addr, 32'h14);
      tick(); tick();
      check("sif_seq_pc", Pc_if2id, 32'h14);
      check("sif_seq_addr", Imem_addr, 32'h18);

      // Redirect twice while the 0x18 response is outstanding.
      hold_rsp = 1'b1;
      tick();
      Redirect = 1'b1; Redirect_pc = 32'h0000_0102;
      tick();
      check("rd_flush_instr", Instr_if2id, NOP);
      check("rd_flush_valid", 32'(Valid_if2id), 32'd0);
      check("rd_wait_req", 32'(Imem_req), 32'd0);
      Redirect_pc = 32'h0000_0200;
      tick();
      Redirect = 1'b0; hold_rsp = 1'b0;
      tick();
      check("rd_stale_req", 32'(Imem_req), 32'd0);
      check("rd_stale_valid", 32'(Valid_if2id), 32'd0);
      tick();
      check("rd_new_req", 32'(Imem_req), 32'd1);
      check("rd_new_addr", Imem_addr, 32'h200);
      check("rd_drop_valid", 32'(Valid_if2id), 32'd0);
      tick(); tick();
      check("rd_tgt_pc", Pc_if2id, 32'h200);
      check("rd_tgt_instr", Instr_if2id, instr_at(32'h200));
      check("rd_tgt_valid", 32'(Valid_if2id), 32'd1);

      Stall_id = 1'b1; Redirect = 1'b1; Redirect_pc = 32'h0000_0300;
      tick();
      check("rs_instr", Instr_if2id, NOP);
      check("rs_valid", 32'(Valid_if2id), 32'd0);
      Stall_id = 1'b0; Redirect = 1'b0;
      tick();
      check("rs_addr", Imem_addr, 32'h300);
      tick(); tick();
      check("rs_pc", Pc_if2id, 32'h300);
      check("rs_deliv_valid", 32'(Valid_if2id), 32'd1);

      Redirect = 1'b1; Redirect_pc = 32'hFFFF_FFFC;
      tick();
      Redirect = 1'b0;
      tick();
      check("wr_addr_top", Imem_addr, 32'hFFFF_FFFC);
      tick(); tick();
      check("wr_pc", Pc_if2id, 32'hFFFF_FFFC);
      check("wr_instr", Instr_if2id, instr_at(32'hFFFF_FFFC));
      check("wr_valid", 32'(Valid_if2id), 32'd1);
      check("wr_next_addr", Imem_addr, 32'h0);
      check("wr_next_req", 32'(Imem_req), 32'd1);

      tick();
      Rst = 1'b1;
      #1;
      check("mid_rst_instr", Instr_if2id, NOP);
      check("mid_rst_pc", Pc_if2id, 32'h0);
      check("mid_rst_valid", 32'(Valid_if2id), 32'd0);
      check("mid_rst_req", 32'(Imem_req), 32'd0);
      tick();
      @(posedge Clk); #1 Rst = 1'b0;
      tick();
      check("post_rst_req", 32'(Imem_req), 32'd1);
      check("post_rst_addr", Imem_addr, 32'h0);
      tick(); tick();
      check("post_rst_pc", Pc_if2id, 32'h0);
      check("post_rst_instr", Instr_if2id, 32'h0050_0093);
      check("post_rst_valid", 32'(Valid_if2id), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
